// File: rtl/fpu_mul_seq.sv
// Sequencing control for a pipelined floating-point multiplier. Tracks valid/tag through
// eight stages (m1, m2, m3a, m3b, m3, m4, m5, m6), decodes the op in m1/m2, picks the
// stage-2 exponent source from the operand classes and keeps an occupancy count.
module fpu_mul_seq #(
  parameter int unsigned TAG_W = 3
) (
  input  logic             rclk,
  input  logic             arst_l,
  input  logic             req_vld,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [1:0]       req_cls1,
  input  logic [1:0]       req_cls2,
  output logic             req_rdy,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [TAG_W-1:0] out_tag,
  output logic             m6stg_step,
  output logic             m1stg_dblop,
  output logic             m1stg_sngop,
  output logic             m1stg_fsmuld,
  output logic             m2stg_exp_expadd,
  output logic             m2stg_exp_0bff,
  output logic             m2stg_exp_017f,
  output logic             m2stg_exp_04ff,
  output logic             m2stg_exp_zero,
  output logic             m2stg_fmuld,
  output logic             m2stg_fmuls,
  output logic             m2stg_fsmuld,
  output logic             fmul_clken_l,
  output logic [3:0]       occ_cnt
);

  localparam int unsigned NStg = 8;

  localparam logic [1:0] OpFmuls  = 2'b01;
  localparam logic [1:0] OpFmuld  = 2'b10;
  localparam logic [1:0] OpFsmuld = 2'b11;

  localparam logic [1:0] ClsZero = 2'b01;
  localparam logic [1:0] ClsInf  = 2'b10;
  localparam logic [1:0] ClsNan  = 2'b11;

  // Select encoding: {expadd, 0bff, 017f, 04ff, zero}
  localparam logic [4:0] SelExpadd = 5'b10000;
  localparam logic [4:0] Sel0bff   = 5'b01000;
  localparam logic [4:0] Sel017f   = 5'b00100;
  localparam logic [4:0] Sel04ff   = 5'b00010;
  localparam logic [4:0] SelZero   = 5'b00001;

  // Valid and tag ride the whole pipe; op and classes are only consumed in m1/m2.
  logic [NStg-1:0]             v_q, v_d;
  logic [NStg-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [1:0][1:0]             op_q, op_d;
  logic [1:0]                  cls1_q, cls1_d, cls2_q, cls2_d;
  logic [4:0]                  sel2_q, sel2_d;
  logic [3:0]                  occ_q, occ_d;

  logic       step, accept, retire;
  logic       any_nan, any_inf, any_zero;
  logic [4:0] sel1;

  assign step   = !(v_q[NStg-1] && !out_rdy);
  assign accept = req_vld && step && (req_op != 2'b00);
  assign retire = v_q[NStg-1] && out_rdy;

  // Exponent source for the op in m1; inf x zero is covered by the inf term.
  always_comb begin
    any_nan  = (cls1_q == ClsNan) || (cls2_q == ClsNan);
    any_inf  = (cls1_q == ClsInf) || (cls2_q == ClsInf);
    any_zero = (cls1_q == ClsZero) || (cls2_q == ClsZero);
    sel1     = SelExpadd;
    if (any_nan || any_inf) begin
      unique case (op_q[0])
        OpFmuls:  sel1 = Sel017f;
        OpFsmuld: sel1 = Sel04ff;
        default:  sel1 = Sel0bff;
      endcase
    end else if (any_zero) begin
      sel1 = SelZero;
    end
  end

  // Shift every stage on step; otherwise hold. Bubbles carry zeroed fields.
  always_comb begin
    v_d    = v_q;
    tag_d  = tag_q;
    op_d   = op_q;
    cls1_d = cls1_q;
    cls2_d = cls2_q;
    sel2_d = sel2_q;
    if (step) begin
      v_d    = {v_q[NStg-2:0], accept};
      tag_d  = {tag_q[NStg-2:0], (accept ? req_tag : {TAG_W{1'b0}})};
      op_d   = {op_q[0], (accept ? req_op : 2'b00)};
      cls1_d = accept ? req_cls1 : 2'b00;
      cls2_d = accept ? req_cls2 : 2'b00;
      sel2_d = v_q[0] ? sel1 : 5'b00000;
    end
  end

  // Occupancy: a simultaneous accept and retire leaves the count unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({accept, retire})
      2'b10:   occ_d = occ_q + 4'd1;
      2'b01:   occ_d = occ_q - 4'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Pipe state with asynchronous clear.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      v_q    <= '0;
      tag_q  <= '0;
      op_q   <= '0;
      cls1_q <= '0;
      cls2_q <= '0;
      sel2_q <= '0;
      occ_q  <= '0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      op_q   <= op_d;
      cls1_q <= cls1_d;
      cls2_q <= cls2_d;
      sel2_q <= sel2_d;
      occ_q  <= occ_d;
    end
  end

  assign req_rdy    = step;
  assign m6stg_step = step;
  assign out_vld    = v_q[NStg-1];
  assign out_tag    = tag_q[NStg-1];
  assign occ_cnt    = occ_q;

  assign m1stg_dblop  = v_q[0] && ((op_q[0] == OpFmuld) || (op_q[0] == OpFsmuld));
  assign m1stg_sngop  = v_q[0] && (op_q[0] == OpFmuls);
  assign m1stg_fsmuld = v_q[0] && (op_q[0] == OpFsmuld);

  assign m2stg_exp_expadd = sel2_q[4];
  assign m2stg_exp_0bff   = sel2_q[3];
  assign m2stg_exp_017f   = sel2_q[2];
  assign m2stg_exp_04ff   = sel2_q[1];
  assign m2stg_exp_zero   = sel2_q[0];

  assign m2stg_fmuld  = v_q[1] && (op_q[1] == OpFmuld);
  assign m2stg_fmuls  = v_q[1] && (op_q[1] == OpFmuls);
  assign m2stg_fsmuld = v_q[1] && (op_q[1] == OpFsmuld);

  assign fmul_clken_l = !(req_vld || (|v_q));

endmodule
